// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the execute-stage multiply/divide unit.
//   mdu_op_t    - MULT / MULTU / DIV / DIVU request encoding
//   mdu_state_t - sequencer states of mult_div_unit
//   MDU_ITER    - radix-2 iteration count for a 32-bit operand
package cpu_types_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_t;

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input mdu_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 iteration.
//   is_div   in  selects restoring-divide step (1) or shift-add multiply step (0)
//   acc_hi   in  upper accumulator (partial product / partial remainder)
//   acc_lo   in  lower accumulator (multiplier bits / dividend-quotient bits)
//   operand  in  multiplicand or divisor magnitude
//   nxt_hi   out upper accumulator after the step
//   nxt_lo   out lower accumulator after the step
module mdu_step
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        nxt_hi  = acc_hi;
        nxt_lo  = acc_lo;
        if (is_div) begin
            // Remainder is kept one bit wider across the shift; a clear
            // borrow bit means the trial subtraction stayed non-negative.
            shifted = {acc_hi, acc_lo[WIDTH-1]};
            diff    = shifted - {1'b0, operand};
            if (!diff[WIDTH]) begin
                nxt_hi = diff[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit beside the execute-stage alu.
//   CLK     in   system clock
//   RST     in   synchronous active-high reset
//   start   in   request strobe, sampled only in IDLE
//   md_op   in   operation (mdu_op_t)
//   port_a  in   multiplicand / dividend
//   port_b  in   multiplier / divisor
//   busy    out  high in every state except IDLE
//   done    out  one-cycle completion pulse
//   hi      out  product upper half or remainder
//   lo      out  product lower half or quotient
//   dz_fl   out  divide-by-zero on the last completed op
// Optional feature macro: MDU_EARLY_OUT_EN (multiply stops once the remaining
// multiplier bits are zero). WIDTH must be a power of two.
module mult_div_unit
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  mdu_op_t          md_op,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz_fl
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = '1;
    localparam logic [CNT_W-1:0] CNT_DEC  = {{(CNT_W-1){1'b0}}, 1'b1};

    mdu_state_t state, state_nxt;
    mdu_op_t    op_q;

    logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
    logic [CNT_W-1:0] cnt;
    logic             res_neg, rem_neg;

    logic             a_neg, b_neg, is_div_req, dz_req, op_is_div;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_hi, step_lo;

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_hi, fix_lo;

`ifdef MDU_EARLY_OUT_EN
    localparam logic [CNT_W:0] SH_FULL = {1'b1, {CNT_W{1'b0}}};
    localparam logic [CNT_W:0] SH_ONE  = {{CNT_W{1'b0}}, 1'b1};

    logic [CNT_W:0] shamt, remain_cnt;
    logic           mul_rem_zero;

    // Low remain_cnt bits of acc_lo are the multiplier bits not yet consumed.
    always_comb begin
        remain_cnt   = {1'b0, cnt} + SH_ONE;
        mul_rem_zero = !op_is_div && ((acc_lo & ~({WIDTH{1'b1}} << remain_cnt)) == '0);
    end
`endif

    // Request decode: magnitudes and signs of the incoming operands.
    always_comb begin
        a_neg      = is_signed_op(md_op) && port_a[WIDTH-1];
        b_neg      = is_signed_op(md_op) && port_b[WIDTH-1];
        mag_a      = a_neg ? ('0 - port_a) : port_a;
        mag_b      = b_neg ? ('0 - port_b) : port_b;
        is_div_req = is_div_op(md_op);
        dz_req     = is_div_req && (port_b == '0);
        op_is_div  = is_div_op(op_q);
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (opnd_b),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    // Sign correction applied on the way out of FIX.
    always_comb begin
        prod = {acc_hi, acc_lo};
`ifdef MDU_EARLY_OUT_EN
        prod = prod >> shamt;
`endif
        prod_fix = res_neg ? ('0 - prod) : prod;
        quot_fix = res_neg ? ('0 - acc_lo) : acc_lo;
        rem_fix  = rem_neg ? ('0 - acc_hi) : acc_hi;
        if (op_is_div) begin
            fix_hi = rem_fix;
            fix_lo = quot_fix;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= MDU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != MDU_IDLE);
        done      = (state == MDU_DONE);
        case (state)
            MDU_IDLE: begin
                if (start) begin
                    if (dz_req) begin
                        state_nxt = MDU_DONE;
`ifdef MDU_EARLY_OUT_EN
                    end else if (!is_div_req && (mag_b == '0)) begin
                        state_nxt = MDU_FIX;
`endif
                    end else begin
                        state_nxt = MDU_CALC;
                    end
                end
            end
            MDU_CALC: begin
`ifdef MDU_EARLY_OUT_EN
                if (mul_rem_zero || (cnt == '0)) begin
                    state_nxt = MDU_FIX;
                end
`else
                if (cnt == '0) begin
                    state_nxt = MDU_FIX;
                end
`endif
            end
            MDU_FIX:  state_nxt = MDU_DONE;
            MDU_DONE: state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q    <= MD_MULT;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd_b  <= '0;
            cnt     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            dz_fl   <= 1'b0;
`ifdef MDU_EARLY_OUT_EN
            shamt   <= '0;
`endif
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (start) begin
                        op_q    <= md_op;
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        cnt     <= CNT_LOAD;
                        acc_hi  <= '0;
                        // Divide: dividend shifts out of acc_lo as quotient
                        // shifts in. Multiply: multiplier sits in acc_lo.
                        acc_lo  <= is_div_req ? mag_a : mag_b;
                        opnd_b  <= is_div_req ? mag_b : mag_a;
`ifdef MDU_EARLY_OUT_EN
                        shamt   <= (!is_div_req && (mag_b == '0)) ? SH_FULL : '0;
`endif
                        if (dz_req) begin
                            hi    <= port_a;
                            lo    <= '1;
                            dz_fl <= 1'b1;
                        end
                    end
                end
                MDU_CALC: begin
`ifdef MDU_EARLY_OUT_EN
                    // On early exit acc holds the product shifted left by the
                    // unconsumed bit count; FIX shifts it back into place.
                    if (mul_rem_zero) begin
                        shamt <= remain_cnt;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_DEC;
                        end
                    end
`else
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_DEC;
                    end
`endif
                end
                MDU_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    dz_fl <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
